div_iter: RTL and testbench

- Parametrised multi-cycle radix-2 restoring integer divider for the execution stage.
- Replaces the vendor-IP divider pair with a single portable datapath.
- Serves signed and unsigned DIV/MOD through one valid/ready request port and one valid/ready response port.
- Supports pipeline flush and defined results for divide-by-zero and signed overflow.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_iter_lzc.sv | 22 ++
 rtl/div_iter.sv | 174 +++++++++++++++++
 tb/tb_div_iter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative divider.
// Provides the FSM state enum and a conditional two's-complement negate.
// No ports; imported by div_iter.
package div_pkg;

    // Widest operand abs_w can handle; callers cast to/from their own width.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIXUP,
        DONE
    } div_state_e;

    // Negate v when neg is set. Truncating the result back to a narrower
    // width still yields the correct two's-complement value in that width.
    function automatic logic [DIV_MAX_W-1:0] abs_w(input logic [DIV_MAX_W-1:0] v,
                                                   input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_iter_lzc.sv
// lzc: combinational leading-zero counter.
// Ports: value (WIDTH) in, count (CNT_W) out = number of leading zeros, WIDTH when value==0.
// Zero latency, no flow control.
module lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last to write count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring signed/unsigned divider, one op in flight.
// Ports: clk, rst (sync, active-high), flush; request in_valid/in_ready with
//   is_signed, dividend, divisor; response out_valid/out_ready with quotient,
//   remainder; busy is high outside IDLE.
// Latency WIDTH+3 cycles from accept to out_valid (shorter with DIV_EARLY_OUT_EN,
//   which skips the dividend's leading zeros); results hold while out_ready is low.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_nxt;

    logic [WIDTH-1:0] a_raw, b_raw, b_abs;
    logic             sgn, q_neg, r_neg;
    logic [WIDTH-1:0] rem, shreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_r, rem_r;

    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_abs_c, b_abs_c;
    logic [WIDTH:0]   rem_sh, trial;
    logic             div_zero, ovf;

    logic [WIDTH-1:0] prep_shreg;
    logic [CNT_W-1:0] prep_cnt;
    logic             skip_calc;

    assign a_neg_c = sgn & a_raw[WIDTH-1];
    assign b_neg_c = sgn & b_raw[WIDTH-1];
    assign a_abs_c = WIDTH'(abs_w(DIV_MAX_W'(a_raw), a_neg_c));
    assign b_abs_c = WIDTH'(abs_w(DIV_MAX_W'(b_raw), b_neg_c));

    // One restoring step; trial's top bit set means the subtraction went negative.
    assign rem_sh = {rem, shreg[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, b_abs};

    assign div_zero = (b_raw == '0);
    assign ovf      = sgn && (a_raw == MIN_INT) && (b_raw == '1);

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    lzc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc (
        .value (a_abs_c),
        .count (lz)
    );

    // Leading zeros would only shift zero quotient bits in, so skip them.
    assign prep_shreg = a_abs_c << lz;
    assign prep_cnt   = CNT_W'(WIDTH) - lz;
    assign skip_calc  = (lz == CNT_W'(WIDTH)) || div_zero;
`else
    assign prep_shreg = a_abs_c;
    assign prep_cnt   = CNT_W'(WIDTH);
    assign skip_calc  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over everything including a new request.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = PREP;
                PREP:    state_nxt = skip_calc ? FIXUP : CALC;
                CALC:    if (cnt == CNT_W'(1)) state_nxt = FIXUP;
                FIXUP:   state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

    // Datapath; frozen during flush so the previous result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_raw <= '0;
            b_raw <= '0;
            b_abs <= '0;
            sgn   <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            rem   <= '0;
            shreg <= '0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_raw <= dividend;
                        b_raw <= divisor;
                        sgn   <= is_signed;
                    end
                end
                PREP: begin
                    q_neg <= a_neg_c ^ b_neg_c;
                    r_neg <= a_neg_c;
                    b_abs <= b_abs_c;
                    rem   <= '0;
                    shreg <= prep_shreg;
                    cnt   <= prep_cnt;
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem   <= trial[WIDTH-1:0];
                        shreg <= {shreg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem   <= rem_sh[WIDTH-1:0];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                end
                FIXUP: begin
                    if (div_zero) begin
                        quo_r <= '1;
                        rem_r <= a_raw;
                    end else if (ovf) begin
                        quo_r <= MIN_INT;
                        rem_r <= '0;
                    end else begin
                        quo_r <= WIDTH'(abs_w(DIV_MAX_W'(shreg), q_neg));
                        rem_r <= WIDTH'(abs_w(DIV_MAX_W'(rem), r_neg));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (WIDTH=32).
// Honours DIV_EARLY_OUT_EN for expected latency and the early-out vectors.
// Reference results come from plain 64-bit integer division.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, is_signed;
    logic         out_valid, out_ready, busy;
    logic [W-1:0] dividend, divisor, quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    // Truncating division with the defined special cases.
    function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        longint unsigned ua, ub;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            ua = longint'(a);
            ub = longint'(b);
            q  = W'(ua / ub);
            r  = W'(ua % ub);
        end
    endfunction

    function automatic int clz(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return W - 1 - i;
        end
        return W;
    endfunction

    // Cycle offset of the first out_valid cycle relative to the accept cycle.
    function automatic int exp_lat(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] mag;
        int z;
        mag = (s && a[W-1]) ? -a : a;
        z   = clz(mag);
`ifdef DIV_EARLY_OUT_EN
        if (z == W || b == '0) return 3;
        return W - z + 3;
`else
        if (b == '0 && z < 0) return 0;
        return W + 3;
`endif
    endfunction

    // Issue one op with out_ready high; returns results, latency (-1 on timeout)
    // and whether in_ready was seen high while the op was in flight.
    task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output bit ir_hi);
        int n;
        ir_hi     = 1'b0;
        lat       = -1;
        out_ready = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        // Scramble inputs; the divider must have sampled them at accept.
        in_valid  = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        dividend  = $urandom;
        divisor   = $urandom;
        n = 1;
        while (!out_valid && n < 200) begin
            if (in_ready) ir_hi = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (out_valid) lat = n;
        if (in_ready) ir_hi = 1'b1;
        q = quotient;
        r = remainder;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl got out_valid,busy,in_ready=%b want 001", {out_valid, busy, in_ready});
        end
        checks++;
        if (quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_result got q=%h r=%h want 0 0", quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t         vt [10];
        logic [W-1:0] q, r;
        int           lat;
        bit           ir_hi;
        vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vt[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
        vt[2] = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
        vt[3] = '{1'b1, 32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000};
        vt[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vt[5] = '{1'b0, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF};
        vt[6] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vt[7] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
        vt[8] = '{1'b0, 32'd5,          32'd2,          32'd2,          32'd1};
        vt[9] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        for (int i = 0; i < 10; i++) begin
            do_op(vt[i].s, vt[i].a, vt[i].b, q, r, lat, ir_hi);
            checks++;
            if (q !== vt[i].q || r !== vt[i].r) begin
                errors++;
                $display("FAIL directed_%0d_result got q=%h r=%h want q=%h r=%h", i, q, r, vt[i].q, vt[i].r);
            end
            checks++;
            if (lat !== exp_lat(vt[i].s, vt[i].a, vt[i].b)) begin
                errors++;
                $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, exp_lat(vt[i].s, vt[i].a, vt[i].b));
            end
            checks++;
            if (ir_hi !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d_in_ready got high-in-flight want low", i);
            end
        end
`ifdef DIV_EARLY_OUT_EN
        do_op(1'b0, 32'd5, 32'd2, q, r, lat, ir_hi);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL early_5_by_2_latency got %0d want 6", lat);
        end
        do_op(1'b1, 32'd0, 32'hFFFFFFF9, q, r, lat, ir_hi);
        checks++;
        if (lat !== 3 || q !== '0 || r !== '0) begin
            errors++;
            $display("FAIL early_zero_dividend got lat=%0d q=%h r=%h want 3 0 0", lat, q, r);
        end
`else
        do_op(1'b0, 32'd100, 32'd7, q, r, lat, ir_hi);
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL fixed_latency got %0d want 35", lat);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_arrival got out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b101 || quotient !== 32'd142 || remainder !== 32'd6) begin
                errors++;
                $display("FAIL bp_hold_%0d got v,ir,busy=%b q=%0d r=%0d want 101 142 6",
                         i, {out_valid, in_ready, busy}, quotient, remainder);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release got v,ir,busy=%b want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_flush();
        int           n;
        bit           saw_valid, saw_busy;
        logic [W-1:0] q, r;
        int           lat;
        bit           ir_hi;
        out_ready = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_busy got %b want 1", busy);
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd7;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL flush_idle got ir,busy,v=%b want 100", {in_ready, busy, out_valid});
        end
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        repeat (50) begin
            if (out_valid) saw_valid = 1'b1;
            if (busy) saw_busy = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_valid || saw_busy) begin
            errors++;
            $display("FAIL flush_no_op got valid_seen=%b busy_seen=%b want 0 0", saw_valid, saw_busy);
        end
        checks++;
        if (quotient !== 32'd142 || remainder !== 32'd6) begin
            errors++;
            $display("FAIL flush_result_kept got q=%0d r=%0d want 142 6", quotient, remainder);
        end
        do_op(1'b0, 32'd9, 32'd3, q, r, lat, ir_hi);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || lat !== exp_lat(1'b0, 32'd9, 32'd3)) begin
            errors++;
            $display("FAIL flush_next_op got q=%0d r=%0d lat=%0d want 3 0 %0d",
                     q, r, lat, exp_lat(1'b0, 32'd9, 32'd3));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        bit           s;
        int           lat, mode;
        bit           ir_hi;
        for (int i = 0; i < 600; i++) begin
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 7);
            a    = $urandom;
            b    = $urandom >> $urandom_range(0, 31);
            case (mode)
                0: b = '0;
                1: begin s = 1'b1; a = 32'h80000000; b = '1; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = -($urandom_range(1, 50));
                4: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            ref_div(s, a, b, eq, er);
            do_op(s, a, b, q, r, lat, ir_hi);
            checks++;
            if (q !== eq || r !== er) begin
                errors++;
                $display("FAIL rand_%0d_result s=%0d a=%h b=%h got q=%h r=%h want q=%h r=%h",
                         i, s, a, b, q, r, eq, er);
            end
            checks++;
            if (lat !== exp_lat(s, a, b) || ir_hi !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d_timing got lat=%0d ir_hi=%b want lat=%0d ir_hi=0",
                         i, lat, ir_hi, exp_lat(s, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
